// File: rtl/register_file_pkg.sv
// register_file_pkg
//   Shared constants for the architectural register file and its read ports.
//   ROB_WIDTH_DEFAULT : default width of a reorder-buffer tag (must match the ROB)
//   REG_COUNT_DEFAULT : number of architectural registers (x0 hardwired to zero)
//   REG_ID_WIDTH      : width of a register index
//   ZERO_REG          : index of the hardwired-zero register
package register_file_pkg;

  localparam int ROB_WIDTH_DEFAULT = 4;
  localparam int REG_COUNT_DEFAULT = 32;
  localparam int REG_ID_WIDTH      = 5;

  localparam logic [REG_ID_WIDTH-1:0] ZERO_REG = '0;

  // True when an index names a real, writable register.
  function automatic logic is_writable(input logic [REG_ID_WIDTH-1:0] id);
    return id != ZERO_REG;
  endfunction

endpackage

// File: rtl/register_file_read_port.sv
// register_file_read_port
//   One combinational lookup port of the register file. Takes the stored entry
//   selected by rs_id and produces the value/busy/tag seen by issue.
//   - x0 always reads value 0, busy 0, tag 0.
//   - Optional commit bypass, enabled by defining RF_COMMIT_BYPASS_EN: when the
//     ROB commits the very tag this register is waiting on in the current cycle,
//     the committed value is forwarded and the register reads as not busy.
//
//   Ports:
//     rs_id        in   register being looked up
//     entry_value  in   stored value of that register
//     entry_busy   in   stored busy flag
//     entry_tag    in   stored producing ROB tag
//     rdy_in       in   global ready (bypass only applies when high)
//     reg_done     in   ROB commit valid
//     reg_id       in   committed register
//     reg_value    in   committed value
//     reg_tag      in   committed ROB tag
//     rs_value     out  looked-up value
//     rs_busy      out  1 = value still pending in the ROB
//     rs_tag       out  producing ROB tag (meaningful when rs_busy)
module register_file_read_port
  import register_file_pkg::*;
#(
  parameter int ROB_WIDTH = ROB_WIDTH_DEFAULT
) (
  input  logic [REG_ID_WIDTH-1:0] rs_id,
  input  logic [31:0]             entry_value,
  input  logic                    entry_busy,
  input  logic [ROB_WIDTH-1:0]    entry_tag,
  input  logic                    rdy_in,
  input  logic                    reg_done,
  input  logic [REG_ID_WIDTH-1:0] reg_id,
  input  logic [31:0]             reg_value,
  input  logic [ROB_WIDTH-1:0]    reg_tag,
  output logic [31:0]             rs_value,
  output logic                    rs_busy,
  output logic [ROB_WIDTH-1:0]    rs_tag
);

`ifdef RF_COMMIT_BYPASS_EN
  localparam bit BYPASS_EN = 1'b1;
`else
  localparam bit BYPASS_EN = 1'b0;
`endif

  logic bypass_hit;

  // Forward only a commit that retires exactly the rename this register holds;
  // a commit of an older tag must not hide a younger pending rename.
  assign bypass_hit = BYPASS_EN && rdy_in && reg_done && is_writable(rs_id) &&
                      (reg_id == rs_id) && entry_busy && (entry_tag == reg_tag);

  always_comb begin
    // NOTE: every output gets a default first so no path through this block
    // leaves a signal unassigned, which would otherwise infer a latch.
    rs_value = entry_value;
    rs_busy  = entry_busy;
    rs_tag   = entry_tag;
    if (!is_writable(rs_id)) begin
      rs_value = '0;
      rs_busy  = 1'b0;
      rs_tag   = '0;
    end else if (bypass_hit) begin
      rs_value = reg_value;
      rs_busy  = 1'b0;
    end
  end

endmodule

// File: rtl/register_file.sv
// register_file
//   Architectural register file with per-register rename tags. Retires ROB
//   commits into x1..x31, records which ROB entry will produce each register,
//   and serves two combinational source lookups to issue. A mispredict clear
//   drops every rename.
//   Optional feature: define RF_COMMIT_BYPASS_EN to let lookups see a
//   same-cycle commit of the tag a register is waiting on.
//
//   Ports:
//     clk_in         in   system clock
//     rst_in         in   synchronous active-high reset (wins over rdy_in)
//     rdy_in         in   global ready; state frozen when low
//     clear_signal   in   mispredict flush: all busy cleared, issue ignored
//     issue_signal   in   an instruction is issued this cycle
//     issue_rd_id    in   destination register of the issued instruction
//     issue_rob_tag  in   ROB entry allocated to it
//     reg_done       in   ROB commits a register result
//     reg_id         in   committed destination register
//     reg_value      in   committed value
//     reg_tag        in   ROB entry being committed
//     rs1_id/rs2_id  in   source register lookups
//     rsN_value      out  register value
//     rsN_busy       out  1 = value pending in ROB, use rsN_tag
//     rsN_tag        out  producing ROB tag (valid when busy)
module register_file
  import register_file_pkg::*;
#(
  parameter int ROB_WIDTH = ROB_WIDTH_DEFAULT,
  parameter int REG_COUNT = REG_COUNT_DEFAULT
) (
  input  logic                    clk_in,
  input  logic                    rst_in,
  input  logic                    rdy_in,
  input  logic                    clear_signal,
  input  logic                    issue_signal,
  input  logic [REG_ID_WIDTH-1:0] issue_rd_id,
  input  logic [ROB_WIDTH-1:0]    issue_rob_tag,
  input  logic                    reg_done,
  input  logic [REG_ID_WIDTH-1:0] reg_id,
  input  logic [31:0]             reg_value,
  input  logic [ROB_WIDTH-1:0]    reg_tag,
  input  logic [REG_ID_WIDTH-1:0] rs1_id,
  input  logic [REG_ID_WIDTH-1:0] rs2_id,
  output logic [31:0]             rs1_value,
  output logic [31:0]             rs2_value,
  output logic                    rs1_busy,
  output logic                    rs2_busy,
  output logic [ROB_WIDTH-1:0]    rs1_tag,
  output logic [ROB_WIDTH-1:0]    rs2_tag
);

  logic [31:0]          value_q [REG_COUNT];
  logic [ROB_WIDTH-1:0] tag_q   [REG_COUNT];
  logic [REG_COUNT-1:0] busy_q;

  logic commit_en;
  logic rename_en;

  assign commit_en = reg_done && is_writable(reg_id);
  assign rename_en = issue_signal && is_writable(issue_rd_id) && !clear_signal;

  // Statement order matters: the rename is written after the commit's busy
  // clear, so a same-cycle issue to the committed register keeps it busy.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      // NOTE: the value/tag arrays are reset here because lookups must read
      // zero straight after reset; this keeps them out of RAM macros.
      for (int i = 0; i < REG_COUNT; i++) begin
        value_q[i] <= '0;
        tag_q[i]   <= '0;
      end
      busy_q <= '0;
    end else if (rdy_in) begin
      // NOTE: non-blocking assignments throughout, so every read in this
      // block sees the pre-edge state regardless of statement order.
      if (commit_en) begin
        value_q[reg_id] <= reg_value;
        // Only the commit of the most recent rename frees the register.
        if (busy_q[reg_id] && (tag_q[reg_id] == reg_tag))
          busy_q[reg_id] <= 1'b0;
      end
      if (clear_signal) begin
        busy_q <= '0;
      end else if (rename_en) begin
        busy_q[issue_rd_id] <= 1'b1;
        tag_q[issue_rd_id]  <= issue_rob_tag;
      end
    end
  end

  register_file_read_port #(.ROB_WIDTH(ROB_WIDTH)) u_rs1_port (
    .rs_id       (rs1_id),
    .entry_value (value_q[rs1_id]),
    .entry_busy  (busy_q[rs1_id]),
    .entry_tag   (tag_q[rs1_id]),
    .rdy_in      (rdy_in),
    .reg_done    (reg_done),
    .reg_id      (reg_id),
    .reg_value   (reg_value),
    .reg_tag     (reg_tag),
    .rs_value    (rs1_value),
    .rs_busy     (rs1_busy),
    .rs_tag      (rs1_tag)
  );

  register_file_read_port #(.ROB_WIDTH(ROB_WIDTH)) u_rs2_port (
    .rs_id       (rs2_id),
    .entry_value (value_q[rs2_id]),
    .entry_busy  (busy_q[rs2_id]),
    .entry_tag   (tag_q[rs2_id]),
    .rdy_in      (rdy_in),
    .reg_done    (reg_done),
    .reg_id      (reg_id),
    .reg_value   (reg_value),
    .reg_tag     (reg_tag),
    .rs_value    (rs2_value),
    .rs_busy     (rs2_busy),
    .rs_tag      (rs2_tag)
  );

endmodule

// File: tb/tb_register_file.sv
// tb_register_file
//   Directed stimulus for register_file with a state-level reference model of
//   the architectural registers, compared on every falling edge, plus literal
//   expectations at key points of each scenario.
module tb_register_file;

  localparam int RW = 4;

  logic          clk_in = 1'b0;
  logic          rst_in;
  logic          rdy_in;
  logic          clear_signal;
  logic          issue_signal;
  logic [4:0]    issue_rd_id;
  logic [RW-1:0] issue_rob_tag;
  logic          reg_done;
  logic [4:0]    reg_id;
  logic [31:0]   reg_value;
  logic [RW-1:0] reg_tag;
  logic [4:0]    rs1_id;
  logic [4:0]    rs2_id;
  logic [31:0]   rs1_value;
  logic [31:0]   rs2_value;
  logic          rs1_busy;
  logic          rs2_busy;
  logic [RW-1:0] rs1_tag;
  logic [RW-1:0] rs2_tag;

  register_file #(.ROB_WIDTH(RW), .REG_COUNT(32)) dut (
    .clk_in        (clk_in),
    .rst_in        (rst_in),
    .rdy_in        (rdy_in),
    .clear_signal  (clear_signal),
    .issue_signal  (issue_signal),
    .issue_rd_id   (issue_rd_id),
    .issue_rob_tag (issue_rob_tag),
    .reg_done      (reg_done),
    .reg_id        (reg_id),
    .reg_value     (reg_value),
    .reg_tag       (reg_tag),
    .rs1_id        (rs1_id),
    .rs2_id        (rs2_id),
    .rs1_value     (rs1_value),
    .rs2_value     (rs2_value),
    .rs1_busy      (rs1_busy),
    .rs2_busy      (rs2_busy),
    .rs1_tag       (rs1_tag),
    .rs2_tag       (rs2_tag)
  );

  always #5 clk_in = ~clk_in;

  int checks_total  = 0;
  int checks_passed = 0;

  task automatic check(input string name, input logic [31:0] actual,
                       input logic [31:0] expected);
    checks_total++;
    if (actual !== expected)
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t",
               name, actual, expected, $time);
    else
      checks_passed++;
  endtask

  // ---------------- reference model: architectural state ----------------
  logic [31:0]   m_value [32];
  bit            m_busy  [32];
  logic [RW-1:0] m_tag   [32];
  bit            model_live = 1'b0;

  always @(posedge clk_in) begin
    if (rst_in) begin
      for (int r = 0; r < 32; r++) begin
        m_value[r] = 32'h0;
        m_busy[r]  = 1'b0;
        m_tag[r]   = '0;
      end
      model_live = 1'b1;
    end else if (rdy_in) begin
      bit retire_pending;
      retire_pending = reg_done && reg_id != 5'd0 &&
                       m_busy[reg_id] && m_tag[reg_id] == reg_tag;
      if (reg_done && reg_id != 5'd0) m_value[reg_id] = reg_value;
      if (retire_pending) m_busy[reg_id] = 1'b0;
      if (clear_signal) begin
        for (int r = 0; r < 32; r++) m_busy[r] = 1'b0;
      end else if (issue_signal && issue_rd_id != 5'd0) begin
        m_busy[issue_rd_id] = 1'b1;
        m_tag[issue_rd_id]  = issue_rob_tag;
      end
    end
  end

  // What issue should see for a register, given the model state and the
  // inputs currently on the commit port.
  task automatic expect_lookup(input logic [4:0] id, output logic [31:0] v,
                               output bit b, output logic [RW-1:0] t);
    v = m_value[id];
    b = m_busy[id];
    t = m_tag[id];
    if (id == 5'd0) begin
      v = 32'h0;
      b = 1'b0;
      t = '0;
    end
`ifdef RF_COMMIT_BYPASS_EN
    else if (rdy_in && reg_done && reg_id == id && b && t == reg_tag) begin
      v = reg_value;
      b = 1'b0;
    end
`endif
  endtask

  always @(negedge clk_in) begin
    if (model_live && !rst_in) begin
      logic [31:0]   ev;
      bit            eb;
      logic [RW-1:0] et;
      expect_lookup(rs1_id, ev, eb, et);
      check("model_rs1_value", rs1_value, ev);
      check("model_rs1_busy", {31'b0, rs1_busy}, {31'b0, eb});
      if (eb) check("model_rs1_tag", {28'b0, rs1_tag}, {28'b0, et});
      expect_lookup(rs2_id, ev, eb, et);
      check("model_rs2_value", rs2_value, ev);
      check("model_rs2_busy", {31'b0, rs2_busy}, {31'b0, eb});
      if (eb) check("model_rs2_tag", {28'b0, rs2_tag}, {28'b0, et});
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic idle();
    clear_signal  = 1'b0;
    issue_signal  = 1'b0;
    issue_rd_id   = 5'd0;
    issue_rob_tag = '0;
    reg_done      = 1'b0;
    reg_id        = 5'd0;
    reg_value     = 32'h0;
    reg_tag       = '0;
  endtask

  // Advance one clock; inputs change 1 time unit after the rising edge.
  task automatic cyc();
    @(posedge clk_in);
    #1;
  endtask

  task automatic issue(input logic [4:0] rd, input logic [RW-1:0] tag);
    issue_signal  = 1'b1;
    issue_rd_id   = rd;
    issue_rob_tag = tag;
  endtask

  task automatic commit(input logic [4:0] rd, input logic [RW-1:0] tag,
                        input logic [31:0] val);
    reg_done  = 1'b1;
    reg_id    = rd;
    reg_tag   = tag;
    reg_value = val;
  endtask

  task automatic lit1(input string name, input logic [31:0] v, input bit b,
                      input logic [RW-1:0] t);
    #1;
    check({name, "_value"}, rs1_value, v);
    check({name, "_busy"}, {31'b0, rs1_busy}, {31'b0, b});
    if (b) check({name, "_tag"}, {28'b0, rs1_tag}, {28'b0, t});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    idle();
    rst_in = 1'b1;
    rdy_in = 1'b1;
    rs1_id = 5'd5;
    rs2_id = 5'd0;
    cyc();
    cyc();
    rst_in = 1'b0;

    // 1: reset state, then rename x5 -> tag 3
    lit1("t1_reset", 32'h0, 1'b0, '0);
    check("t1_reset_tag", {28'b0, rs1_tag}, 32'h0);
    issue(5'd5, 4'd3);
    cyc(); idle();
    lit1("t1_rename", 32'h0, 1'b1, 4'd3);

    // 2: commit x5 tag 3
    rs2_id = 5'd5;
    commit(5'd5, 4'd3, 32'hDEAD_BEEF);
    cyc(); idle();
    lit1("t2_commit", 32'hDEAD_BEEF, 1'b0, '0);

    // 3: double rename of x7; older commit must not free it
    rs1_id = 5'd7;
    issue(5'd7, 4'd2);
    cyc();
    issue(5'd7, 4'd6);
    cyc(); idle();
    lit1("t3_renamed", 32'h0, 1'b1, 4'd6);
    commit(5'd7, 4'd2, 32'h11);
    cyc(); idle();
    lit1("t3_old_commit", 32'h11, 1'b1, 4'd6);
    commit(5'd7, 4'd6, 32'h22);
    cyc(); idle();
    lit1("t3_new_commit", 32'h22, 1'b0, '0);

    // 4: same-cycle issue and commit on x9
    rs1_id = 5'd9;
    rs2_id = 5'd7;
    issue(5'd9, 4'd1);
    cyc(); idle();
    issue(5'd9, 4'd4);
    commit(5'd9, 4'd1, 32'h99);
    cyc(); idle();
    lit1("t4_issue_wins", 32'h99, 1'b1, 4'd4);

    // 5: clear drops renames and ignores the simultaneous issue; x0 immune
    issue(5'd3, 4'd1); cyc();
    issue(5'd4, 4'd2); cyc();
    issue(5'd31, 4'd7); cyc(); idle();
    rs1_id = 5'd31;
    rs2_id = 5'd3;
    lit1("t5_pre_clear", 32'h0, 1'b1, 4'd7);
    clear_signal = 1'b1;
    issue(5'd8, 4'd5);
    cyc(); idle();
    lit1("t5_x31_cleared", 32'h0, 1'b0, '0);
    check("t5_x3_cleared", {31'b0, rs2_busy}, 32'h0);
    rs1_id = 5'd8;
    rs2_id = 5'd4;
    lit1("t5_x8_not_renamed", 32'h0, 1'b0, '0);
    check("t5_x4_cleared", {31'b0, rs2_busy}, 32'h0);
    rs1_id = 5'd0;
    issue(5'd0, 4'd2);
    commit(5'd0, 4'd0, 32'hFF);
    cyc(); idle();
    lit1("t5_x0", 32'h0, 1'b0, '0);
    check("t5_x0_tag", {28'b0, rs1_tag}, 32'h0);

    // 6: rdy_in low freezes state
    rs1_id = 5'd10;
    issue(5'd10, 4'd5);
    cyc(); idle();
    rdy_in = 1'b0;
    issue(5'd10, 4'd9);
    commit(5'd10, 4'd5, 32'hABC);
    cyc();
    cyc(); idle();
    lit1("t6_frozen", 32'h0, 1'b1, 4'd5);
    rdy_in = 1'b1;

    // 6b: same-cycle commit of rs1's pending tag
    commit(5'd10, 4'd5, 32'h5A5A);
`ifdef RF_COMMIT_BYPASS_EN
    lit1("t6_bypass", 32'h5A5A, 1'b0, '0);
`else
    lit1("t6_no_bypass", 32'h0, 1'b1, 4'd5);
`endif
    cyc(); idle();
    lit1("t6_committed", 32'h5A5A, 1'b0, '0);

    // Reset overrides rdy_in low
    issue(5'd12, 4'd3);
    cyc(); idle();
    rs1_id = 5'd12;
    rdy_in = 1'b0;
    rst_in = 1'b1;
    cyc();
    rst_in = 1'b0;
    rdy_in = 1'b1;
    rs2_id = 5'd7;
    lit1("t7_reset_no_rdy", 32'h0, 1'b0, '0);
    check("t7_x7_value_reset", rs2_value, 32'h0);

    cyc();
    @(negedge clk_in);
    #1;
    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule

// File: doc/register_file.md
Name: register_file

Overview:
- Architectural register file with per-register rename tags. Sits downstream of the reorder buffer's commit port and beside instruction fetch/issue.
- It retires committed results into x1..x31.
- It records which ROB entry will produce each register.
- It serves issue with combinational rs1/rs2 lookups of value, busy flag and tag. Issue then asks the ROB whether a busy tag is already ready.
- On a mispredict clear, it drops all renames.

Parameters:
- ROB_WIDTH, 4, width of a ROB tag; must match the reorder buffer.
- REG_COUNT, 32, number of architectural registers; x0 hardwired to zero.

Ports:
- clk_in  input  1  system clock
- rst_in  input  1  synchronous active-high reset
- rdy_in  input  1  global ready; state frozen when low
- clear_signal  input  1  mispredict flush from ROB
- issue_signal  input  1  an instruction is issued this cycle
- issue_rd_id  input  5  destination register of issued instruction
- issue_rob_tag  input  ROB_WIDTH  ROB entry allocated to it (ROB rob_tag)
- reg_done  input  1  ROB commits a register result
- reg_id  input  5  committed destination register
- reg_value  input  32  committed value
- reg_tag  input  ROB_WIDTH  ROB entry being committed
- rs1_id  input  5  source register 1 lookup
- rs2_id  input  5  source register 2 lookup
- rs1_value  output  32  register value (combinational)
- rs2_value  output  32
- rs1_busy  output  1  1 = value pending in ROB, use rs1_tag
- rs2_busy  output  1
- rs1_tag  output  ROB_WIDTH  producing ROB tag (valid when busy)
- rs2_tag  output  ROB_WIDTH

Behaviour:
- State: value[0..31] (32b), busy[0..31], tag[0..31].
- Reset (rst_in high at posedge, regardless of rdy_in): all values 0, all busy 0, all tags 0.
- Lookup outputs are combinational from current state, so all outputs read 0 after reset.
- rdy_in low: no state change. Combinational outputs still track state.
- Commit, when rdy_in and reg_done and reg_id != 0:
  - value[reg_id] <= reg_value, unconditionally.
  - busy[reg_id] <= 0 only if busy[reg_id] and tag[reg_id] == reg_tag. A younger rename keeps the register busy.
- Issue, when rdy_in and issue_signal and issue_rd_id != 0 and not clear_signal:
  - busy[issue_rd_id] <= 1.
  - tag[issue_rd_id] <= issue_rob_tag.
- Same-cycle issue and commit to the same register: the issue rename wins for busy/tag; the commit still writes the value.
- Clear, when rdy_in and clear_signal:
  - All busy <= 0. Tags are don't-care. Any commit value write in that cycle still applies.
  - Issue is ignored in the clear cycle.
- x0: writes and renames are ignored. Reads of x0 return value 0, busy 0, tag 0.
- Lookup in the same cycle as an issue returns pre-issue state. An instruction with rd == rs reads the old mapping.
- Lookup does not see a same-cycle commit (registered state only) unless RF_COMMIT_BYPASS_EN is defined.
- Latency: commit and rename become visible on lookup one cycle after the posedge that samples them.

Optional Feature:
- Macro: RF_COMMIT_BYPASS_EN.
- Defined: a lookup bypasses the same-cycle commit when all of the following hold: rdy_in, reg_done, reg_id == rs_id != 0, busy[rs_id], tag[rs_id] == reg_tag. The output is then value = reg_value and busy = 0. This removes the one-cycle window in which issue would otherwise take a tag whose ROB entry is already freed.
- Undefined: outputs are purely registered state. In that case issue must cover the gap via the ROB's ready lookup.

Decomposition:
- Shared package: ROB_WIDTH default, REG_COUNT, REG_ID_WIDTH=5, and the zero-register constant.
- One natural sub-module: register_file_read_port, instantiated twice (rs1, rs2). It contains the x0 masking and the optional bypass mux.

Test Plan:
1. Reset, then read rs1_id=5 -> value 0, busy 0, tag 0. Issue rd=5 tag=3 -> next cycle rs1_busy=1, rs1_tag=3.
2. After test 1, commit reg_id=5 tag=3 value 0xDEADBEEF -> next cycle value 0xDEADBEEF, busy 0.
3. Rename x7 to tag 2, then to tag 6. Commit x7 tag 2 value 0x11 -> value 0x11, busy 1, tag 6. Commit tag 6 value 0x22 -> busy 0, value 0x22.
4. Same cycle: issue rd=9 tag 4 and commit x9 tag 1 (x9 previously tag 1) -> busy 1, tag 4, value = committed value.
5. Rename x3, x4, x31. Assert clear_signal together with issue rd=8 tag 5 -> all busy 0; x8 not renamed. Issue x0 tag 2 and commit x0 0xFF -> x0 reads 0/0/0.
6. rdy_in low with issue and commit active -> no change. With RF_COMMIT_BYPASS_EN defined, same-cycle commit of rs1's busy tag -> rs1_value = reg_value, rs1_busy 0 combinationally.
